// File: rtl/bank_cmd_scheduler_if.sv
// Request/command bus between the request queue, the bank scheduler and command_sender.
// Latency: none (wires only).
// Backpressure: req_ready_out from the scheduler gates acceptance of req_valid_in.
// Ports: req_* carry one DRAM request into the scheduler; cmd_valid_out/cmd_out plus the
//        target fields (bg/ba/row/col/val) carry the issued command; busy_out reports a
//        request in flight.
interface bank_cmd_scheduler_if #(
  parameter int BANK_GROUPS     = 2,
  parameter int BANKS_PER_GROUP = 4,
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 4
);
  localparam int BG_W = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1;
  localparam int BA_W = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1;

  logic                req_valid_in;
  logic                req_ready_out;
  logic                req_write_in;
  logic [BG_W-1:0]     req_bg_in;
  logic [BA_W-1:0]     req_ba_in;
  logic [ROW_BITS-1:0] req_row_in;
  logic [COL_BITS-1:0] req_col_in;
  logic [7:0][63:0]    req_val_in;

  logic                cmd_valid_out;
  logic [2:0]          cmd_out;
  logic [BG_W-1:0]     bg_out;
  logic [BA_W-1:0]     ba_out;
  logic [ROW_BITS-1:0] row_out;
  logic [COL_BITS-1:0] col_out;
  logic [7:0][63:0]    val_out;
  logic                busy_out;

  // Requester / command consumer side.
  modport master (
    output req_valid_in, req_write_in, req_bg_in, req_ba_in, req_row_in, req_col_in, req_val_in,
    input  req_ready_out, cmd_valid_out, cmd_out, bg_out, ba_out, row_out, col_out, val_out,
    input  busy_out
  );

  // Scheduler side.
  modport slave (
    input  req_valid_in, req_write_in, req_bg_in, req_ba_in, req_row_in, req_col_in, req_val_in,
    output req_ready_out, cmd_valid_out, cmd_out, bg_out, ba_out, row_out, col_out, val_out,
    output busy_out
  );
endinterface

// File: rtl/bank_cmd_scheduler.sv
// DRAM bank command scheduler: one request at a time, open-page policy, PRE/ACT/RD/WR.
// Latency: first command one cycle after accept; ACT->col ACTIVATION_LATENCY, PRE->ACT PRECHARGE_LATENCY.
// Backpressure: req_ready_out only in IDLE; ready again BURST_CYCLES after the column command.
// Ports: clk_in/rst_in (async, active-high) plain; bus (slave modport) carries request in,
//        registered command/address/data out, and busy_out.
module bank_cmd_scheduler #(
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_CYCLES       = 8,
  parameter int BANK_GROUPS        = 2,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4
) (
  input logic                 clk_in,
  input logic                 rst_in,
  bank_cmd_scheduler_if.slave bus
);
  localparam int BG_W      = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1;
  localparam int BA_W      = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1;
  localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int MAX_LAT   = (ACTIVATION_LATENCY > PRECHARGE_LATENCY)
                           ? ((ACTIVATION_LATENCY > BURST_CYCLES) ? ACTIVATION_LATENCY : BURST_CYCLES)
                           : ((PRECHARGE_LATENCY > BURST_CYCLES) ? PRECHARGE_LATENCY : BURST_CYCLES);
  localparam int CNT_W     = $clog2(MAX_LAT) + 1;

  // A wait state lasts (latency-1) cycles; the counter counts down to zero, so load latency-2.
  localparam logic [CNT_W-1:0] PRE_LOAD   = CNT_W'((PRECHARGE_LATENCY  > 1) ? PRECHARGE_LATENCY  - 2 : 0);
  localparam logic [CNT_W-1:0] ACT_LOAD   = CNT_W'((ACTIVATION_LATENCY > 1) ? ACTIVATION_LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'((BURST_CYCLES       > 1) ? BURST_CYCLES       - 2 : 0);

  localparam logic [2:0] CMD_READ  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_ACT   = 3'd2;
  localparam logic [2:0] CMD_PRE   = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_PRE, S_ACT, S_WAIT_ACT, S_COL, S_WAIT_BURST
  } state_t;

  state_t              r_state, w_next_state;
  logic [CNT_W-1:0]    r_cnt, w_next_cnt;

  logic [NUM_BANKS-1:0] r_open;
  logic [ROW_BITS-1:0]  r_open_row [NUM_BANKS];

  logic                r_write;
  logic [BANK_W-1:0]   r_bank;
  logic                r_cmd_vld;
  logic [2:0]          r_cmd;
  logic [BG_W-1:0]     r_bg;
  logic [BA_W-1:0]     r_ba;
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic [7:0][63:0]    r_val;

  logic                w_accept;
  logic [BANK_W-1:0]   w_req_bank;
  logic                w_cmd_vld;
  logic [2:0]          w_cmd_code;
  logic                w_write;

  assign w_accept   = bus.req_valid_in && (r_state == S_IDLE);
  assign w_req_bank = BANK_W'(bus.req_bg_in) * BANK_W'(BANKS_PER_GROUP) + BANK_W'(bus.req_ba_in);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!r_open[w_req_bank])                          w_next_state = S_ACT;
          else if (r_open_row[w_req_bank] == bus.req_row_in) w_next_state = S_COL;
          else                                               w_next_state = S_PRE;
        end
      end
      S_PRE: begin
        if (PRECHARGE_LATENCY > 1) begin
          w_next_state = S_WAIT_PRE;
          w_next_cnt   = PRE_LOAD;
        end else begin
          w_next_state = S_ACT;
        end
      end
      S_WAIT_PRE: begin
        if (r_cnt == '0) w_next_state = S_ACT;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      S_ACT: begin
        if (ACTIVATION_LATENCY > 1) begin
          w_next_state = S_WAIT_ACT;
          w_next_cnt   = ACT_LOAD;
        end else begin
          w_next_state = S_COL;
        end
      end
      S_WAIT_ACT: begin
        if (r_cnt == '0) w_next_state = S_COL;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      S_COL: begin
        if (BURST_CYCLES > 1) begin
          w_next_state = S_WAIT_BURST;
          w_next_cnt   = BURST_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_BURST: begin
        if (r_cnt == '0) w_next_state = S_IDLE;
        else             w_next_cnt   = r_cnt - 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: the command registers are loaded on entry to a command state, so the
  // command is visible during the cycle the FSM spends in PRE/ACT/COL.
  always_comb begin
    w_write    = w_accept ? bus.req_write_in : r_write;
    w_cmd_vld  = 1'b0;
    w_cmd_code = r_cmd;
    case (w_next_state)
      S_PRE: begin w_cmd_vld = 1'b1; w_cmd_code = CMD_PRE; end
      S_ACT: begin w_cmd_vld = 1'b1; w_cmd_code = CMD_ACT; end
      S_COL: begin w_cmd_vld = 1'b1; w_cmd_code = w_write ? CMD_WRITE : CMD_READ; end
      default: ;
    endcase
  end

  // Registered outputs, request latch and open-row table.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cmd_vld <= 1'b0;
      r_cmd     <= '0;
      r_write   <= 1'b0;
      r_bank    <= '0;
      r_bg      <= '0;
      r_ba      <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_val     <= '0;
      r_open    <= '0;
      for (int i = 0; i < NUM_BANKS; i++) r_open_row[i] <= '0;
    end else begin
      r_cmd_vld <= w_cmd_vld;
      if (w_cmd_vld) r_cmd <= w_cmd_code;
      // Address fields change only at accept, which coincides with the first command.
      if (w_accept) begin
        r_write <= bus.req_write_in;
        r_bank  <= w_req_bank;
        r_bg    <= bus.req_bg_in;
        r_ba    <= bus.req_ba_in;
        r_row   <= bus.req_row_in;
        r_col   <= bus.req_col_in;
        r_val   <= bus.req_val_in;
      end
      if (r_state == S_PRE) r_open[r_bank] <= 1'b0;
      if (r_state == S_ACT) begin
        r_open[r_bank]     <= 1'b1;
        r_open_row[r_bank] <= r_row;
      end
    end
  end

  assign bus.req_ready_out = (r_state == S_IDLE);
  assign bus.busy_out      = (r_state != S_IDLE);
  assign bus.cmd_valid_out = r_cmd_vld;
  assign bus.cmd_out       = r_cmd;
  assign bus.bg_out        = r_bg;
  assign bus.ba_out        = r_ba;
  assign bus.row_out       = r_row;
  assign bus.col_out       = r_col;
  assign bus.val_out       = r_val;
endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Testbench for bank_cmd_scheduler: scoreboard of expected commands with issue cycles.
// Latency: n/a.
// Backpressure: requests are held until req_ready_out, with bounded waits.
module tb_bank_cmd_scheduler;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  bank_cmd_scheduler_if bus ();
  bank_cmd_scheduler dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  typedef struct {
    logic [2:0]   cmd;
    logic [0:0]   bg;
    logic [1:0]   ba;
    logic [7:0]   row;
    logic [3:0]   col;
    logic [511:0] val;
    int           at;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_ready = 0;
  logic prev_vld = 1'b0;
  bit   tb_open [8];
  logic [7:0] tb_row [8];

  always @(posedge clk_in) cyc++;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Command monitor: every valid command must match the head of the scoreboard.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (bus.cmd_valid_out) begin
        check("vld_single_cycle", 512'(prev_vld), 512'(0));
        check("cmd_expected", 512'(sb_q.size() != 0), 512'(1));
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("cmd_code",  512'(bus.cmd_out), 512'(mon_e.cmd));
          check("cmd_cycle", 512'(cyc),         512'(mon_e.at));
          check("cmd_bg",    512'(bus.bg_out),  512'(mon_e.bg));
          check("cmd_ba",    512'(bus.ba_out),  512'(mon_e.ba));
          check("cmd_row",   512'(bus.row_out), 512'(mon_e.row));
          if (mon_e.cmd <= 3'd1) check("cmd_col", 512'(bus.col_out), 512'(mon_e.col));
          if (mon_e.cmd == 3'd1) check("wr_val",  512'(bus.val_out), mon_e.val);
        end
      end
      prev_vld = bus.cmd_valid_out;
    end else begin
      prev_vld = 1'b0;
    end
  end

  function automatic exp_t mk(input logic [2:0] cmd, input int bg, input int ba,
                              input int row, input int col, input logic [511:0] val, input int at);
    exp_t e;
    e.cmd = cmd; e.bg = 1'(bg); e.ba = 2'(ba); e.row = 8'(row); e.col = 4'(col);
    e.val = val; e.at = at;
    return e;
  endfunction

  // Push the expected command sequence for a request accepted at negedge cycle c.
  task automatic model_push(input bit wr, input int bg, input int ba, input int row,
                            input int col, input logic [511:0] v, input int c);
    int idx;
    logic [2:0] cc;
    idx = bg * 4 + ba;
    cc  = wr ? 3'd1 : 3'd0;
    if (tb_open[idx] && tb_row[idx] == 8'(row)) begin
      sb_q.push_back(mk(cc, bg, ba, row, col, v, c + 1));
      exp_ready = c + 9;
    end else if (tb_open[idx]) begin
      sb_q.push_back(mk(3'd3, bg, ba, row, col, v, c + 1));
      sb_q.push_back(mk(3'd2, bg, ba, row, col, v, c + 6));
      sb_q.push_back(mk(cc,   bg, ba, row, col, v, c + 14));
      exp_ready = c + 22;
    end else begin
      sb_q.push_back(mk(3'd2, bg, ba, row, col, v, c + 1));
      sb_q.push_back(mk(cc,   bg, ba, row, col, v, c + 9));
      exp_ready = c + 17;
    end
    tb_open[idx] = 1'b1;
    tb_row[idx]  = 8'(row);
  endtask

  task automatic send(input bit wr, input int bg, input int ba, input int row, input int col);
    logic [511:0] v;
    int t;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    bus.req_valid_in = 1'b1;
    bus.req_write_in = wr;
    bus.req_bg_in    = 1'(bg);
    bus.req_ba_in    = 2'(ba);
    bus.req_row_in   = 8'(row);
    bus.req_col_in   = 4'(col);
    bus.req_val_in   = v;
    t = 0;
    while (!bus.req_ready_out && t < 200) begin @(negedge clk_in); t++; end
    check("accept_timeout", 512'(bus.req_ready_out), 512'(1));
    model_push(wr, bg, ba, row, col, v, cyc);
    @(negedge clk_in);
    // Inputs are free to change after acceptance.
    bus.req_valid_in = 1'b0;
    bus.req_write_in = ~wr;
    bus.req_row_in   = 8'($urandom);
    bus.req_col_in   = 4'($urandom);
    bus.req_val_in   = '0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!bus.req_ready_out && t < 100) begin @(negedge clk_in); t++; end
    check("ready_cycle", 512'(cyc), 512'(exp_ready));
  endtask

  initial begin
    int c, prev_c, t;
    bus.req_valid_in = 1'b0;
    bus.req_write_in = 1'b0;
    bus.req_bg_in    = '0;
    bus.req_ba_in    = '0;
    bus.req_row_in   = '0;
    bus.req_col_in   = '0;
    bus.req_val_in   = '0;
    for (int i = 0; i < 8; i++) begin tb_open[i] = 1'b0; tb_row[i] = '0; end

    repeat (3) @(negedge clk_in);
    check("rst_ready",   512'(bus.req_ready_out), 512'(1));
    check("rst_busy",    512'(bus.busy_out),      512'(0));
    check("rst_cmd_vld", 512'(bus.cmd_valid_out), 512'(0));
    check("rst_cmd",     512'(bus.cmd_out),       512'(0));
    check("rst_row",     512'(bus.row_out),       512'(0));
    check("rst_val",     512'(bus.val_out),       512'(0));
    rst_in = 1'b0;
    @(negedge clk_in);

    // Closed bank, then hit, then conflict write.
    send(1'b0, 0, 0, 5, 2);  wait_ready();
    send(1'b0, 0, 0, 5, 7);  wait_ready();
    send(1'b1, 0, 0, 9, 3);  wait_ready();
    // Other bank independent; earlier bank still open.
    send(1'b0, 1, 3, 9, 1);  wait_ready();
    send(1'b0, 0, 0, 9, 4);  wait_ready();

    // Reset in the middle of WAIT_ACT.
    send(1'b0, 0, 1, 3, 6);
    repeat (2) @(negedge clk_in);
    check("busy_mid", 512'(bus.busy_out), 512'(1));
    rst_in = 1'b1;
    #1;
    check("rst_mid_vld",   512'(bus.cmd_valid_out), 512'(0));
    check("rst_mid_busy",  512'(bus.busy_out),      512'(0));
    check("rst_mid_ready", 512'(bus.req_ready_out), 512'(1));
    sb_q.delete();
    for (int i = 0; i < 8; i++) tb_open[i] = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_ready", 512'(bus.req_ready_out), 512'(1));
    send(1'b0, 0, 1, 3, 6);  wait_ready();

    // Back-to-back hits with valid held high.
    bus.req_valid_in = 1'b1;
    bus.req_write_in = 1'b0;
    bus.req_bg_in    = 1'b0;
    bus.req_ba_in    = 2'd1;
    bus.req_row_in   = 8'd3;
    prev_c = 0;
    for (int n = 0; n < 3; n++) begin
      bus.req_col_in = 4'(n + 4);
      t = 0;
      while (!bus.req_ready_out && t < 50) begin @(negedge clk_in); t++; end
      check("hold_accept_timeout", 512'(bus.req_ready_out), 512'(1));
      c = cyc;
      model_push(1'b0, 0, 1, 3, n + 4, '0, c);
      if (n > 0) check("hit_spacing", 512'(c - prev_c), 512'(9));
      prev_c = c;
      @(negedge clk_in);
    end
    bus.req_valid_in = 1'b0;

    repeat (30) @(negedge clk_in);
    check("sb_empty", 512'(sb_q.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
